imem_responder: RTL and testbench
=================================

# imem_responder

Read-only responder (slave) end of the `c2c_r` bus, serving instruction fetches from an on-chip word-organised memory. It sits between the core's instruction-fetch master and a synchronous 1R1W RAM, and returns a registered data word with a single-cycle `ack` per request. Halfword-aligned (compressed-instruction) fetches are split into two RAM reads and merged. A side load port lets boot logic or testbenches preload the image.

## Interface
- `XLEN`, 32, address width of `c2c_r.addr`
- `DEPTH_WORDS`, 4096, RAM depth in 32-bit words (power of two)
- `WAIT_STATES`, 0, extra idle cycles inserted after each RAM read (0–15)
- `INIT_FILE`, "", hex file for `$readmemh` preload; empty means no preload

Ports:
- `clk`  in  1  clock
- `reset_n`  in  1  reset, asynchronous, active-low
- `instr_bus`  c2c_r.slave  –  in: `re`, `addr[XLEN-1:0]`, `sel[3:0]`; out: `data[31:0]`, `ack`
- `ld_we`  in  1  load-port write enable
- `ld_addr`  in  $clog2(DEPTH_WORDS)  load word index
- `ld_data`  in  32  load word
- `err`  out  1  sticky error flag; cleared only by reset

## Operation
- Reset values: `ack`=0, `data`=0, `err`=0, FSM=IDLE.
- FSM states: IDLE, RD_LO, RD_HI, WAIT, ACK.
- IDLE: if `re`=1, latch `addr` and `sel`, issue a RAM read of word `addr[..:2]`, and go to RD_LO. Otherwise stay in IDLE.
- RD_LO:
  - Capture the RAM word as `w0`.
  - If latched `addr[1]`=1, issue a read of word+1 and go to RD_HI.
  - Otherwise go to WAIT if `WAIT_STATES`>0, else go to ACK.
- RD_HI: capture `w1`, then go to WAIT or ACK as above.
- WAIT: counter loads `WAIT_STATES`-1 on entry and decrements each cycle. Go to ACK when the counter reaches 0.
- ACK: assert `ack` for exactly one cycle, with `data` registered. Return to IDLE.
- Data assembly:
  - Aligned access: `data`=`w0`.
  - Halfword-offset access: `data`={`w1[15:0]`, `w0[31:16]`}.
  - Byte lane i with `sel[i]`=0 is forced to 0.
- `data` holds its value after `ack` until the next ACK.
- Errors (the access still completes and acks):
  - `addr[0]`=1: treat the access as if `addr[0]`=0, and set `err`.
  - Word index ≥ `DEPTH_WORDS`: that word reads as 0, and set `err`.
  - Misaligned access whose word+1 overflows the RAM: the upper half is 0, and set `err`.
- `re` dropping mid-transaction has no effect: the access completes and `ack` still pulses. The master must ignore it.
- Load port: a write occurs whenever `ld_we`=1, in any state. A write and a read to the same word in the same cycle return the old data.

## Timing
- Request sampled on the rising edge where state=IDLE and `re`=1; call this cycle 0.
- Aligned access: `ack` in cycle 1+`WAIT_STATES`+1.
  - With `WAIT_STATES`=0, `ack` is high in cycle 2, i.e. 2 cycles after acceptance.
- Misaligned access: one extra cycle, giving 3+`WAIT_STATES` cycles.
- A new request can be accepted no earlier than the cycle after ACK. Peak aligned throughput is one word per 3 cycles at `WAIT_STATES`=0.
- The master must hold `addr`/`sel` until `ack`. The responder nonetheless uses only the latched copies.
- Reset assertion mid-transaction drops `ack`/`data`/`err` to 0 and the FSM to IDLE immediately (asynchronously). RAM contents are preserved.

## Structure
- Shared package `c2c_pkg`:
  - `resp_state_t` enum (IDLE, RD_LO, RD_HI, WAIT, ACK)
  - `C2C_SEL_ALL` = 4'b1111
  - `C2C_ERR_DATA` = 32'h0
- Sub-module `sync_ram_1r1w`:
  - parameters `WIDTH`=32, `DEPTH`, `INIT_FILE`
  - one registered read port and one write port
  - 1-cycle read latency
  - read-during-write to the same address returns old data
- Top level contains the FSM, wait counter, `w0`/`w1` capture registers, lane masking, range checks and the `err` flag.

## Test plan
- Aligned read: preload word 4 = 32'hDEADBEEF; `re`=1, `addr`=0x10, `sel`=4'hF → `ack` exactly 2 cycles later with `data`=0xDEADBEEF; `err`=0.
- Misaligned read: word 4 = 0x1111AAAA, word 5 = 0xBBBB2222; `addr`=0x12 → `ack` 3 cycles later with `data`=0x2222_1111.
- Wait states and masking: `WAIT_STATES`=3, `addr`=0x10, `sel`=4'b0011 → `ack` 5 cycles later with `data`=0x0000BEEF.
- Out of range: `DEPTH_WORDS`=16, `addr`=0x40 → `ack` with `data`=0 and `err`=1; `err` stays 1 until reset.
- Reset mid-op: assert `reset_n`=0 one cycle after acceptance → `ack` never pulses. After release, a new read of 0x10 returns 0xDEADBEEF.
- Load collision: `ld_we` writes word 4 = 0x12345678 in the same cycle a read of 0x10 is accepted → old value 0xDEADBEEF is returned. The next read returns 0x12345678.

Source files
------------

// File: rtl/c2c_pkg.sv
// Shared types and constants for the c2c_r instruction bus and its responders.
package c2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_LO,
    RD_HI,
    WAIT,
    ACK
  } resp_state_t;

  localparam logic [3:0]  C2C_SEL_ALL  = 4'b1111;
  localparam logic [31:0] C2C_ERR_DATA = 32'h0;

  // Zero every byte lane whose select bit is clear.
  function automatic logic [31:0] lane_mask(input logic [31:0] word, input logic [3:0] sel);
    logic [31:0] masked;
    for (int i = 0; i < 4; i++) begin
      masked[8*i +: 8] = sel[i] ? word[8*i +: 8] : 8'h00;
    end
    return masked;
  endfunction

endpackage

// File: rtl/c2c_r.sv
// Read-only c2c bus: master issues re/addr/sel, responder returns data with a one-cycle ack.
interface c2c_r #(
  parameter int XLEN = 32
);
  logic            re;
  logic [XLEN-1:0] addr;
  logic [3:0]      sel;
  logic [31:0]     data;
  logic            ack;

  modport master (output re, output addr, output sel, input data, input ack);
  modport slave  (input re, input addr, input sel, output data, output ack);
endinterface

// File: rtl/sync_ram_1r1w.sv
// Synchronous 1R1W RAM: registered read with one-cycle latency, read-during-write returns old data.
module sync_ram_1r1w #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 4096,
  parameter     INIT_FILE = "",
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  input  logic             we,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the array has no reset so it maps onto block RAM; contents survive reset_n.
  always_ff @(posedge clk) begin
    rd_data <= mem[rd_addr];
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

endmodule

// File: rtl/imem_responder.sv
// Read-only c2c_r responder serving instruction fetches from a word RAM, with
// halfword-offset fetches split into two reads and merged.
module imem_responder
  import c2c_pkg::*;
#(
  parameter int  XLEN        = 32,
  parameter int  DEPTH_WORDS = 4096,
  parameter int  WAIT_STATES = 0,
  parameter      INIT_FILE   = "",
  localparam int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          reset_n,
  c2c_r.slave           instr_bus,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_addr,
  input  logic [31:0]   ld_data,
  output logic          err
);

  localparam int IW = XLEN - 2;
  localparam int CW = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
  localparam logic [IW:0] DEPTH_LIM = (IW+1)'(DEPTH_WORDS);

  resp_state_t   state;
  logic [IW-1:0] idx_q;
  logic          mis_q;
  logic          lo_oor_q;
  logic [3:0]    sel_q;
  logic [31:0]   w0, w1;
  logic [CW-1:0] wait_cnt;
  logic [31:0]   data_q;
  logic          ack_q;

  logic [IW-1:0] bus_idx;
  logic          bus_oor;
  logic [IW:0]   hi_idx;
  logic          hi_oor;
  logic [AW-1:0] ram_rd_addr;
  logic [31:0]   ram_rd_data;
  logic [31:0]   lo_word, hi_word, w0_n, w1_n, assembled;

  assign bus_idx = instr_bus.addr[XLEN-1:2];
  assign bus_oor = {1'b0, bus_idx} >= DEPTH_LIM;
  // One extra bit so word+1 at the top of the address space cannot wrap.
  assign hi_idx  = {1'b0, idx_q} + (IW+1)'(1);
  assign hi_oor  = hi_idx >= DEPTH_LIM;

  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin
    ram_rd_addr = hi_idx[AW-1:0];
    if (state == IDLE) begin
      ram_rd_addr = bus_idx[AW-1:0];
    end
    lo_word   = lo_oor_q ? C2C_ERR_DATA : ram_rd_data;
    hi_word   = hi_oor   ? C2C_ERR_DATA : ram_rd_data;
    w0_n      = (state == RD_LO) ? lo_word : w0;
    w1_n      = (state == RD_HI) ? hi_word : w1;
    assembled = lane_mask(mis_q ? {w1_n[15:0], w0_n[31:16]} : w0_n, sel_q);
  end

  sync_ram_1r1w #(
    .WIDTH     (32),
    .DEPTH     (DEPTH_WORDS),
    .INIT_FILE (INIT_FILE)
  ) u_ram (
    .clk     (clk),
    .rd_addr (ram_rd_addr),
    .rd_data (ram_rd_data),
    .we      (ld_we),
    .wr_addr (ld_addr),
    .wr_data (ld_data)
  );

  // NOTE: all state here uses non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      idx_q    <= '0;
      mis_q    <= 1'b0;
      lo_oor_q <= 1'b0;
      sel_q    <= C2C_SEL_ALL;
      w0       <= '0;
      w1       <= '0;
      wait_cnt <= '0;
      data_q   <= '0;
      ack_q    <= 1'b0;
      err      <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (instr_bus.re) begin
            idx_q    <= bus_idx;
            mis_q    <= instr_bus.addr[1];
            sel_q    <= instr_bus.sel;
            lo_oor_q <= bus_oor;
            err      <= err | instr_bus.addr[0] | bus_oor;
            state    <= RD_LO;
          end
        end
        RD_LO: begin
          w0 <= lo_word;
          if (mis_q) begin
            err   <= err | hi_oor;
            state <= RD_HI;
          end else if (WAIT_STATES > 0) begin
            wait_cnt <= CW'(WAIT_STATES - 1);
            state    <= WAIT;
          end else begin
            data_q <= assembled;
            ack_q  <= 1'b1;
            state  <= ACK;
          end
        end
        RD_HI: begin
          w1 <= hi_word;
          if (WAIT_STATES > 0) begin
            wait_cnt <= CW'(WAIT_STATES - 1);
            state    <= WAIT;
          end else begin
            data_q <= assembled;
            ack_q  <= 1'b1;
            state  <= ACK;
          end
        end
        WAIT: begin
          if (wait_cnt == '0) begin
            data_q <= assembled;
            ack_q  <= 1'b1;
            state  <= ACK;
          end else begin
            wait_cnt <= wait_cnt - CW'(1);
          end
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign instr_bus.data = data_q;
  assign instr_bus.ack  = ack_q;

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: one zero-wait 4096-word instance and one
// 3-wait-state 16-word instance sharing clock and reset.
module tb_imem_responder;
  import c2c_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        ld_we0, ld_we1;
  logic [11:0] ld_addr0;
  logic [3:0]  ld_addr1;
  logic [31:0] ld_data0, ld_data1;
  logic        err0, err1;

  int checks = 0;
  int errors = 0;

  c2c_r #(.XLEN(32)) bus0 ();
  c2c_r #(.XLEN(32)) bus1 ();

  imem_responder #(
    .XLEN(32), .DEPTH_WORDS(4096), .WAIT_STATES(0), .INIT_FILE("")
  ) u_dut0 (
    .clk(clk), .reset_n(reset_n), .instr_bus(bus0),
    .ld_we(ld_we0), .ld_addr(ld_addr0), .ld_data(ld_data0), .err(err0)
  );

  imem_responder #(
    .XLEN(32), .DEPTH_WORDS(16), .WAIT_STATES(3), .INIT_FILE("")
  ) u_dut1 (
    .clk(clk), .reset_n(reset_n), .instr_bus(bus1),
    .ld_we(ld_we1), .ld_addr(ld_addr1), .ld_data(ld_data1), .err(err1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive_req(input bit u, input logic re, input logic [31:0] a, input logic [3:0] s);
    if (u) begin
      bus1.re = re; bus1.addr = a; bus1.sel = s;
    end else begin
      bus0.re = re; bus0.addr = a; bus0.sel = s;
    end
  endtask

  // Called at a negedge; the word is written on the following rising edge.
  task automatic load(input bit u, input int idx, input logic [31:0] v);
    if (u) begin
      ld_we1 = 1'b1; ld_addr1 = idx[3:0]; ld_data1 = v;
    end else begin
      ld_we0 = 1'b1; ld_addr0 = idx[11:0]; ld_data0 = v;
    end
    @(negedge clk);
    ld_we0 = 1'b0;
    ld_we1 = 1'b0;
  endtask

  // Latency c means the master sees ack at rising edge c after the accepting edge 0;
  // ack is sampled on the negedge just before that edge. An optional load of the
  // same word is issued in the acceptance cycle.
  task automatic read_chk(input string tag, input bit u, input logic [31:0] a,
                          input logic [3:0] s, input logic [31:0] exp_data,
                          input int exp_lat, input logic exp_err,
                          input bit ld = 1'b0, input logic [31:0] ld_val = 32'h0);
    int          lat;
    logic [31:0] got;
    lat = -1;
    got = 'x;
    drive_req(u, 1'b1, a, s);
    if (ld) begin
      ld_we0 = 1'b1; ld_addr0 = a[13:2]; ld_data0 = ld_val;
    end
    @(posedge clk);
    #1;
    // Drop re and scramble addr/sel: only the latched request may be used.
    drive_req(u, 1'b0, 32'hFFFF_FFFC, 4'h0);
    ld_we0 = 1'b0;
    for (int c = 1; c <= 20 && lat < 0; c++) begin
      @(negedge clk);
      if (u ? bus1.ack : bus0.ack) begin
        lat = c;
        got = u ? bus1.data : bus0.data;
      end
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " data"}, got, exp_data);
    @(negedge clk);
    check({tag, " ack pulse"}, {31'b0, u ? bus1.ack : bus0.ack}, 32'h0);
    check({tag, " data hold"}, u ? bus1.data : bus0.data, exp_data);
    check({tag, " err"}, {31'b0, u ? err1 : err0}, {31'b0, exp_err});
  endtask

  initial begin
    int acks;
    reset_n = 1'b1;
    drive_req(1'b0, 1'b0, 32'h0, 4'h0);
    drive_req(1'b1, 1'b0, 32'h0, 4'h0);
    ld_we0 = 1'b0; ld_addr0 = '0; ld_data0 = '0;
    ld_we1 = 1'b0; ld_addr1 = '0; ld_data1 = '0;
    #1 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset ack", {31'b0, bus0.ack}, 32'h0);
    check("reset data", bus0.data, 32'h0);
    check("reset err", {31'b0, err0}, 32'h0);
    reset_n = 1'b1;
    @(negedge clk);

    // Aligned, halfword-offset and lane-masked reads, zero wait states.
    load(1'b0, 4, 32'hDEAD_BEEF);
    read_chk("aligned", 1'b0, 32'h10, C2C_SEL_ALL, 32'hDEAD_BEEF, 2, 1'b0);
    load(1'b0, 4, 32'h1111_AAAA);
    load(1'b0, 5, 32'hBBBB_2222);
    read_chk("misaligned", 1'b0, 32'h12, C2C_SEL_ALL, 32'h2222_1111, 3, 1'b0);
    read_chk("misaligned mask", 1'b0, 32'h12, 4'b1100, 32'h2222_0000, 3, 1'b0);
    load(1'b0, 4, 32'hDEAD_BEEF);
    read_chk("aligned mask", 1'b0, 32'h10, 4'b0101, 32'h00AD_00EF, 2, 1'b0);

    // Three wait states, 16-word RAM; word 0 is non-zero so index aliasing shows up.
    load(1'b1, 0, 32'hFFFF_FFFF);
    load(1'b1, 4, 32'hDEAD_BEEF);
    load(1'b1, 15, 32'hCAFE_5555);
    read_chk("wait mask", 1'b1, 32'h10, 4'b0011, 32'h0000_BEEF, 5, 1'b0);
    read_chk("out of range", 1'b1, 32'h40, C2C_SEL_ALL, 32'h0, 5, 1'b1);
    read_chk("top overflow", 1'b1, 32'h3E, C2C_SEL_ALL, 32'h0000_CAFE, 6, 1'b1);
    read_chk("err sticky", 1'b1, 32'h10, C2C_SEL_ALL, 32'hDEAD_BEEF, 5, 1'b1);

    // Odd address behaves as even and raises err.
    read_chk("odd addr", 1'b0, 32'h11, C2C_SEL_ALL, 32'hDEAD_BEEF, 2, 1'b1);

    // Reset one half-cycle after acceptance: ack must never appear.
    drive_req(1'b0, 1'b1, 32'h10, C2C_SEL_ALL);
    @(posedge clk);
    #1 drive_req(1'b0, 1'b0, 32'hFFFF_FFFC, 4'h0);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midop reset ack", {31'b0, bus0.ack}, 32'h0);
    check("midop reset data0", bus0.data, 32'h0);
    check("midop reset err0", {31'b0, err0}, 32'h0);
    check("midop reset data1", bus1.data, 32'h0);
    check("midop reset err1", {31'b0, err1}, 32'h0);
    acks = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus0.ack) acks++;
    end
    reset_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (bus0.ack) acks++;
    end
    check("midop no ack", 32'(acks), 32'h0);
    read_chk("after reset", 1'b0, 32'h10, C2C_SEL_ALL, 32'hDEAD_BEEF, 2, 1'b0);

    // Load and read of the same word in the acceptance cycle.
    read_chk("collision old", 1'b0, 32'h10, C2C_SEL_ALL, 32'hDEAD_BEEF, 2, 1'b0,
             1'b1, 32'h1234_5678);
    read_chk("collision new", 1'b0, 32'h10, C2C_SEL_ALL, 32'h1234_5678, 2, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
